// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_t;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 RAM with synchronous write and synchronous read.
// rdata only changes on a read, so it holds the last word fetched.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDXW        = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [IDXW-1:0] idx,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= r_mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: wait-state FSM, combinational Stall, registered response.
// Optional error reporting (misaligned / out-of-range / MemRd&MemWr) is enabled by DMEM_ERR_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Address,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        Stall,
  output logic        Resp_valid
`ifdef DMEM_ERR_EN
  ,
  output logic        Err
`endif
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  state_t            r_state;
  logic [3:0]        r_count;
  op_t               r_op;
  logic [IDXW-1:0]   r_idx;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic              r_errFlag;

  logic              w_req;
  logic              w_reqErr;
  logic [IDXW-1:0]   w_reqIdx;
  logic [IDXW-1:0]   w_ramIdx;
  logic              w_we;
  logic              w_re;
  logic [31:0]       w_rdata;

  assign w_req    = MemRd | MemWr;
  assign w_reqIdx = Address[IDXW+1:2];

`ifdef DMEM_ERR_EN
  assign w_reqErr = (Address[1:0] != 2'b00) | (|Address[31:IDXW+2]) | (MemRd & MemWr);
  assign Err      = r_errFlag;
`else
  logic w_unused;
  assign w_reqErr = 1'b0;
  assign w_unused = ^{Address[31:IDXW+2], Address[1:0], r_errFlag};
`endif

  assign Stall = (r_state == WAIT) | ((r_state == IDLE) & w_req);

  // The RAM is read at acceptance; nothing else can write it before the response.
  assign w_re     = (r_state == IDLE) & MemRd & ~MemWr & ~reset;
  assign w_we     = (r_state == WAIT) & (r_count == 4'd0) & (r_op == OP_STORE) & ~r_err & ~reset;
  assign w_ramIdx = (r_state == IDLE) ? w_reqIdx : r_idx;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDXW        (IDXW)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .re    (w_re),
    .idx   (w_ramIdx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_op       <= OP_LOAD;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_err      <= 1'b0;
      r_errFlag  <= 1'b0;
      Data_out   <= 32'd0;
      Resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          Resp_valid <= 1'b0;
          r_errFlag  <= 1'b0;
          if (w_req) begin
            r_op    <= MemWr ? OP_STORE : OP_LOAD;
            r_idx   <= w_reqIdx;
            r_wdata <= Data_in;
            r_err   <= w_reqErr;
            r_count <= 4'(LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state    <= DONE;
            Resp_valid <= 1'b1;
            r_errFlag  <= r_err;
            if (r_op == OP_LOAD) begin
              Data_out <= r_err ? ERR_DATA : w_rdata;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        // The request is still on the inputs here; it has completed and must not be re-accepted.
        DONE: begin
          Resp_valid <= 1'b0;
          r_errFlag  <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          Resp_valid <= 1'b0;
          r_errFlag  <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random loads/stores
// checked against a word-array reference model (honours DMEM_ERR_EN when defined).
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Address;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        Stall;
  logic        Resp_valid;
`ifdef DMEM_ERR_EN
  logic        Err;
`endif

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lastResp = 0;
  int          firstResp;
  logic [31:0] model [DEPTH];
  logic [31:0] expData;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .Address    (Address),
    .Data_in    (Data_in),
    .Data_out   (Data_out),
    .Stall      (Stall),
    .Resp_valid (Resp_valid)
`ifdef DMEM_ERR_EN
    ,
    .Err        (Err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      MemRd = 1'b0; MemWr = 1'b0; Address = $urandom; Data_in = $urandom;
      #1;
      check("idle_stall", 32'(Stall), 32'd0);
      check("idle_resp", 32'(Resp_valid), 32'd0);
      check("idle_hold", Data_out, expData);
`ifdef DMEM_ERR_EN
      check("idle_err", 32'(Err), 32'd0);
`endif
    end
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Address = 32'd0; Data_in = 32'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    expData = 32'd0;
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_resp", 32'(Resp_valid), 32'd0);
    check("rst_data", Data_out, 32'd0);
`ifdef DMEM_ERR_EN
    check("rst_err", 32'(Err), 32'd0);
`endif
  endtask

  // One full request: inputs held in the accept and DONE cycles, scrambled while waiting.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    logic        err;
    int          idx;
    logic [31:0] loadVal;
    err     = ERR_EN && ((addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH)) || (rd && wr));
    idx     = int'((addr >> 2) % DEPTH);
    loadVal = err ? 32'hDEADBEEF : model[idx];
    for (int k = 0; k <= LAT + 1; k++) begin
      @(posedge clk); #2;
      MemRd = rd; MemWr = wr;
      if (k == 0 || k == LAT + 1) begin
        Address = addr; Data_in = data;
      end else begin
        Address = $urandom; Data_in = $urandom;
      end
      #1;
      check("stall", 32'(Stall), 32'(k <= LAT));
      check("resp_valid", 32'(Resp_valid), 32'(k == LAT + 1));
      if (k == LAT + 1) begin
        lastResp = cyc;
        if (!wr) expData = loadVal;
        check("data_out", Data_out, expData);
`ifdef DMEM_ERR_EN
        check("err", 32'(Err), 32'(err));
`endif
      end
    end
    if (wr && !err) model[idx] = data;
  endtask

  initial begin
    reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Address = 32'd0; Data_in = 32'd0;
    expData = 32'd0;
    doReset();

    applyStimulus(1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h0, 32'h11111111);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h22222222);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h5A5A0008);
    for (int w = 2; w < 16; w++) begin
      if (w != 4 && w != 8) applyStimulus(1'b0, 1'b1, 32'(w * 4), $urandom);
    end
    idleCycles(2);

    applyStimulus(1'b1, 1'b0, 32'h0, 32'd0);
    firstResp = lastResp;
    applyStimulus(1'b1, 1'b0, 32'h4, 32'd0);
    check("b2b_spacing", 32'(lastResp - firstResp), 32'(LAT + 2));
    idleCycles(2);

    // Store to 0x20 aborted by reset on the edge where it would have written.
    @(posedge clk); #2;
    MemWr = 1'b1; Address = 32'h20; Data_in = 32'hBAD0BAD0;
    #1 check("abort_stall0", 32'(Stall), 32'd1);
    @(posedge clk); #3;
    check("abort_stall1", 32'(Stall), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check("abort_stall2", 32'(Stall), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0; MemWr = 1'b0; Address = 32'd0; Data_in = 32'd0;
    #1;
    expData = 32'd0;
    check("abort_stall_low", 32'(Stall), 32'd0);
    check("abort_resp_low", 32'(Resp_valid), 32'd0);
    check("abort_data_rst", Data_out, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'd0);

    applyStimulus(1'b1, 1'b0, 32'h400, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h77777777);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'd0);
    idleCycles(1);

    for (int i = 0; i < 40; i++) begin
      int          w;
      int          sel;
      logic [31:0] a;
      w   = $urandom_range(0, 15);
      sel = $urandom_range(0, 9);
      a   = 32'($urandom_range(0, 3)) * 32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3));
      if (sel < 6)      applyStimulus(1'b1, 1'b0, a, $urandom);
      else if (sel < 9) applyStimulus(1'b0, 1'b1, a, $urandom);
      else              applyStimulus(1'b1, 1'b1, a, $urandom);
      idleCycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
